fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 67 ++++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared front-end definitions: default fetch geometry, reset PC and the
// instruction-queue entry payload.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned DEF_PC_W  = 9;
   localparam int unsigned DEF_DEPTH = 2;

   localparam logic [XLEN-1:0] RESET_PC = '0;

   // One fetched instruction together with the byte PC it was read from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } fq_entry_t;

   // Instruction fetch is word aligned: the two low address bits are dropped.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched instructions with a synchronous flush used
// to discard the wrong path on a redirect.
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       wr_en,
   input  fq_entry_t                  wr_data,
   input  logic                       rd_en,
   output fq_entry_t                  rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fq_entry_t       mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [CW-1:0]   cnt;
   logic            do_wr;
   logic            do_rd;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // A read on a full queue frees the slot the same-cycle write lands in.
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign rd_data = mem[rptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_wr) begin
            mem[wptr] <= wr_data;
            wptr      <= ptr_inc(wptr);
         end
         if (do_rd) begin
            rptr <= ptr_inc(rptr);
         end
         cnt <= cnt + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches under a credit limit,
// tags them with a redirect epoch and queues in-epoch responses for decode.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned PC_W  = DEF_PC_W,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [31:0]     redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [PC_W-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [PC_W-1:0] inst_pc
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PC_W-1:0]  fetch_pc;
   logic             epoch;
   logic [CW-1:0]    outstanding;
   logic [AW-1:0]    ot_wptr;
   logic [AW-1:0]    ot_rptr;
   logic [PC_W-1:0]  ot_pc [DEPTH];
   logic [DEPTH-1:0] ot_tag;

   logic             credit_ok;
   logic             req_fire;
   logic             rsp_take;
   logic             rsp_keep;
   logic             out_fire;

   fq_entry_t        q_wdata;
   fq_entry_t        q_head;
   logic             q_full;
   logic             q_empty;
   logic [CW-1:0]    q_count;
   logic             unused_sink;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Every issued request reserves a queue slot until it is consumed.
   assign credit_ok      = (SW'(outstanding) + SW'(q_count)) < SW'(DEPTH);
   assign imem_req_valid = credit_ok && !redirect_valid && !reset;
   assign imem_req_addr  = fetch_pc;

   assign req_fire = imem_req_valid && imem_req_ready;
   assign out_fire = inst_valid && inst_ready;

   // Responses with nothing outstanding belong to requests issued before reset.
   assign rsp_take = imem_rsp_valid && (outstanding != '0);
   assign rsp_keep = rsp_take && (ot_tag[ot_rptr] == epoch) && !redirect_valid;

   always_comb begin
      q_wdata      = '0;
      q_wdata.pc   = XLEN'(ot_pc[ot_rptr]);
      q_wdata.data = imem_rsp_data;
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .flush   (redirect_valid),
      .wr_en   (rsp_keep),
      .wr_data (q_wdata),
      .rd_en   (out_fire),
      .rd_data (q_head),
      .full    (q_full),
      .empty   (q_empty),
      .count   (q_count)
   );

   assign inst_valid  = !q_empty;
   assign inst_data   = q_head.data;
   assign inst_pc     = q_head.pc[PC_W-1:0];
   assign unused_sink = ^{q_head.pc[XLEN-1:PC_W], q_full};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= PC_W'(RESET_PC);
         epoch       <= 1'b0;
         outstanding <= '0;
         ot_wptr     <= '0;
         ot_rptr     <= '0;
         ot_tag      <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ot_pc[i] <= '0;
         end
      end else begin
         if (redirect_valid) begin
            fetch_pc <= PC_W'(align_word(redirect_pc));
            epoch    <= ~epoch;
         end else if (req_fire) begin
            fetch_pc <= fetch_pc + PC_W'(4);
         end

         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);

         if (req_fire) begin
            ot_pc[ot_wptr] <= fetch_pc;
            ot_wptr        <= ptr_inc(ot_wptr);
         end
         if (rsp_take) begin
            ot_rptr <= ptr_inc(ot_rptr);
         end

         // Stamp all in-flight requests stale so back-to-back redirects cannot
         // make an old tag match the epoch again.
         if (redirect_valid) begin
            ot_tag <= {DEPTH{epoch}};
         end else if (req_fire) begin
            ot_tag[ot_wptr] <= epoch;
         end
      end
   end

endmodule
